// File: rtl/bcd_scan_encoder_if.sv
// Digit/anode-select bus between the BCD scan encoder (slave side here) and its
// user: binary load request in, scanned BCD digit and anode number out.
interface bcd_scan_encoder_if #(
  parameter int BIN_W = 27
);
  logic [BIN_W-1:0] bin_in;
  logic             load;
  logic             blank_lz;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       v;
  logic [2:0]       anum;
  logic             blank;

  modport master (
    output bin_in, load, blank_lz,
    input  busy, done, overflow, v, anum, blank
  );

  modport slave (
    input  bin_in, load, blank_lz,
    output busy, done, overflow, v, anum, blank
  );
endinterface

// File: rtl/bcd_scan_encoder.sv
// Sequential double-dabble binary-to-BCD converter (8 digits) feeding a
// prescaled digit scanner with optional leading-zero blanking.
module bcd_scan_encoder #(
  parameter int BIN_W       = 27,
  parameter int REFRESH_DIV = 100000
) (
  input logic              clk,
  input logic              reset,
  bcd_scan_encoder_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(64'd99_999_999);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

  logic [1:0]       state_reg;
  logic [BIN_W-1:0] shift_reg;
  logic [31:0]      acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic [31:0]      disp_reg;
  logic             overflow_reg;

  logic [PRE_W-1:0] pre_reg;
  logic [2:0]       anum_reg;
  logic [3:0]       v_reg;
  logic             blank_reg;

  logic [27:0]      acc_adj;
  logic [31:0]      src_digits;
  logic [8:0]       lz;
  logic             pre_wrap;
  logic [2:0]       anum_next;
  logic [3:0]       digit_sel;

  // The top nibble is never adjusted: inputs are clamped below 10^8, so it
  // never holds 5 or more before a shift.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end
  endgenerate

  // During the commit cycle the scanner samples the accumulator directly so
  // the new digits appear on v on the very next cycle.
  assign src_digits = (state_reg == ST_COMMIT) ? acc_reg : disp_reg;

  // lz[i] = digit i and every digit above it are zero.
  assign lz[8] = 1'b1;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lz
      assign lz[gi] = lz[gi+1] && (src_digits[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  assign pre_wrap  = (pre_reg == LAST_PRE);
  assign anum_next = pre_wrap ? anum_reg + 3'd1 : anum_reg;
  assign digit_sel = src_digits[{anum_next, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      disp_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.load) begin
            shift_reg <= (bus.bin_in > MAX_BIN) ? MAX_BIN : bus.bin_in;
            ovf_reg   <= (bus.bin_in > MAX_BIN);
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_reg   <= {acc_reg[30:28], acc_adj, shift_reg[BIN_W-1]};
          shift_reg <= shift_reg << 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp_reg     <= acc_reg;
          overflow_reg <= ovf_reg;
          state_reg    <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_reg   <= '0;
      anum_reg  <= '0;
      v_reg     <= '0;
      blank_reg <= 1'b0;
    end else begin
      pre_reg   <= pre_wrap ? '0 : pre_reg + 1'b1;
      anum_reg  <= anum_next;
      v_reg     <= digit_sel;
      blank_reg <= bus.blank_lz && (anum_next != 3'd0) && lz[anum_next];
    end
  end

  assign bus.busy     = (state_reg == ST_SHIFT);
  assign bus.done     = (state_reg == ST_COMMIT);
  assign bus.overflow = overflow_reg;
  assign bus.v        = v_reg;
  assign bus.anum     = anum_reg;
  assign bus.blank    = blank_reg;

endmodule

// File: tb/tb_bcd_scan_encoder.sv
// Randomized self-checking bench for bcd_scan_encoder; expected digits come from
// decimal arithmetic on the loaded value, expected slots from elapsed cycles.
module tb_bcd_scan_encoder;
  localparam int BIN_W = 27;
  localparam int DIV   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_scan_encoder_if #(.BIN_W(BIN_W)) bus ();

  bcd_scan_encoder #(.BIN_W(BIN_W), .REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     checks   = 0;
  int     failures = 0;
  int     tcount   = 0;
  longint exp_val  = 0;
  logic   exp_ovf  = 1'b0;
  logic   blz      = 1'b0;

  // Cycles elapsed since the last reset edge; the slot is tcount/DIV mod 8.
  always @(posedge clk) begin
    if (reset) tcount <= 0;
    else       tcount <= tcount + 1;
  end

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  task automatic check_scan(input int n);
    for (int c = 0; c < n; c++) begin
      int   a;
      int   dv;
      logic bl;
      a  = (tcount / DIV) % 8;
      dv = int'((exp_val / pow10(a)) % 10);
      bl = blz && (a != 0) && (exp_val < pow10(a));
      checks++;
      if (bus.anum !== 3'(a)) begin
        failures++;
        $display("FAIL scan_anum: got %0d expected %0d (t=%0d)", bus.anum, a, tcount);
      end
      checks++;
      if (bus.v !== 4'(dv)) begin
        failures++;
        $display("FAIL scan_v: slot %0d got %0d expected %0d (value %0d)", a, bus.v, dv, exp_val);
      end
      checks++;
      if (bus.blank !== bl) begin
        failures++;
        $display("FAIL scan_blank: slot %0d got %0b expected %0b (value %0d)", a, bus.blank, bl, exp_val);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_conv(input longint val, input logic lz);
    blz          = lz;
    bus.blank_lz = lz;
    bus.bin_in   = BIN_W'(val);
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int j = 1; j <= 28; j++) begin
      if (j > 1) @(negedge clk);
      checks++;
      if (bus.busy !== (j <= 27)) begin
        failures++;
        $display("FAIL conv_busy: cycle %0d got %0b expected %0b", j, bus.busy, (j <= 27));
      end
      checks++;
      if (bus.done !== (j == 28)) begin
        failures++;
        $display("FAIL conv_done: cycle %0d got %0b expected %0b", j, bus.done, (j == 28));
      end
    end
    @(negedge clk);
    exp_ovf = (val > 99_999_999);
    exp_val = exp_ovf ? 64'd99_999_999 : val;
    checks++;
    if (bus.overflow !== exp_ovf) begin
      failures++;
      $display("FAIL conv_overflow: value %0d got %0b expected %0b", val, bus.overflow, exp_ovf);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL conv_done_clear: got %0b expected 0", bus.done);
    end
    check_scan(32);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({bus.busy, bus.done, bus.overflow, bus.blank} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_flags: got busy/done/ovf/blank=%b expected 0000", tag,
               {bus.busy, bus.done, bus.overflow, bus.blank});
    end
    checks++;
    if (bus.anum !== 3'd0) begin
      failures++;
      $display("FAIL %s_anum: got %0d expected 0", tag, bus.anum);
    end
    checks++;
    if (bus.v !== 4'd0) begin
      failures++;
      $display("FAIL %s_v: got %0d expected 0", tag, bus.v);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.bin_in   = '0;
    bus.blank_lz = 1'b0;
    blz          = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_release");
    check_scan(8);
  endtask

  task automatic test_basic();
    run_conv(12_345_678, 1'b0);
  endtask

  task automatic test_overflow();
    run_conv(123_456_789, 1'b0);
    run_conv(5, 1'b0);
  endtask

  task automatic test_blanking();
    run_conv(0, 1'b1);
    run_conv(100, 1'b1);
  endtask

  task automatic test_load_ignored();
    int dones = 0;
    blz          = 1'b0;
    bus.blank_lz = 1'b0;
    bus.bin_in   = BIN_W'(24_681_357);
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) @(negedge clk);
      if (bus.done) dones++;
      checks++;
      if (bus.done !== (j == 28)) begin
        failures++;
        $display("FAIL ignore_done: cycle %0d got %0b expected %0b", j, bus.done, (j == 28));
      end
      if (j == 5) begin
        bus.bin_in = BIN_W'(11_111_111);
        bus.load   = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignore_done_count: got %0d expected 1", dones);
    end
    @(negedge clk);
    exp_val = 24_681_357;
    exp_ovf = 1'b0;
    check_scan(32);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    bus.bin_in = BIN_W'(87_654_321);
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    reset   = 1'b0;
    exp_val = 0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset_release");
    check_scan(8);
    for (int j = 0; j < 40; j++) begin
      if (bus.done) dones++;
      checks++;
      if (bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL midreset_busy: cycle %0d got %0b expected 0", j, bus.busy);
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midreset_done_count: got %0d expected 0", dones);
    end
  endtask

  task automatic test_free_run();
    check_scan(40);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    blz          = 1'b0;
    bus.blank_lz = 1'b0;
    bus.bin_in   = BIN_W'(90_807_060);
    bus.load     = 1'b1;
    for (int j = 1; j <= 58; j++) begin
      @(negedge clk);
      if (bus.done) dones++;
      checks++;
      if (bus.done !== (j == 28 || j == 57)) begin
        failures++;
        $display("FAIL b2b_done: cycle %0d got %0b expected %0b", j, bus.done, (j == 28 || j == 57));
      end
    end
    bus.load = 1'b0;
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d expected 2", dones);
    end
    @(negedge clk);
    exp_val = 90_807_060;
    exp_ovf = 1'b0;
    check_scan(32);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      int     r;
      longint val;
      r = int'($urandom_range(0, 3));
      if (r == 0)      val = longint'($urandom_range(0, (1 << BIN_W) - 1));
      else if (r == 1) val = longint'($urandom_range(0, 999));
      else             val = longint'($urandom_range(0, 99_999_999));
      run_conv(val, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_blanking();
    test_load_ignored();
    test_reset_mid();
    test_free_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
